// File: rtl/msrv32_imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_imem_responder_if
// Description : Fetch bus between the stage-1 PC logic (master) and the
//               instruction memory responder (slave).
//               fetch_req_in / imaddr_in   : address phase, master -> slave
//               ahb_ready_out              : slave accepting / data done
//               instr_valid_out/instr_out  : data phase, slave -> master
//               err_out / err_cause_out    : fetch error, qualified by valid
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_imem_responder_if;

    logic        fetch_req_in;
    logic [31:0] imaddr_in;
    logic        ahb_ready_out;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic        err_out;
    logic [1:0]  err_cause_out;

    modport master (
        output fetch_req_in,
        output imaddr_in,
        input  ahb_ready_out,
        input  instr_valid_out,
        input  instr_out,
        input  err_out,
        input  err_cause_out
    );

    modport slave (
        input  fetch_req_in,
        input  imaddr_in,
        output ahb_ready_out,
        output instr_valid_out,
        output instr_out,
        output err_out,
        output err_cause_out
    );

endinterface
`default_nettype wire

// File: rtl/msrv32_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_imem_responder
// Description : Instruction-side memory responder. Accepts word fetch
//               addresses while ready is high, inserts WAIT_STATES ready-low
//               cycles, then presents the instruction for one data-phase
//               cycle. Misaligned and out-of-range fetches complete with the
//               same timing but return a NOP and an error cause. The word
//               array is written through a preload port for simulation/boot.
// Ports       : ms_riscv32_mp_clk_in  - clock, rising edge
//               ms_riscv32_mp_rst_in  - asynchronous active-low reset
//               bus (slave modport)   - fetch address/data bus
//               load_en_in            - preload write strobe
//               load_addr_in          - preload word index
//               load_data_in          - preload word
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_imem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic                     ms_riscv32_mp_clk_in,
    input  wire logic                     ms_riscv32_mp_rst_in,
    msrv32_imem_responder_if.slave        bus,
    input  wire logic                     load_en_in,
    input  wire logic [$clog2(DEPTH)-1:0] load_addr_in,
    input  wire logic [31:0]              load_data_in
);

    localparam int          c_AW             = $clog2(DEPTH);
    localparam logic [31:0] c_NOP            = 32'h0000_0013;
    localparam logic [1:0]  c_CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  c_CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  c_CAUSE_RANGE    = 2'b10;
    // Counter preload on accept: the WAIT state is left when the count is 0,
    // so WAIT_STATES-1 gives exactly WAIT_STATES ready-low cycles.
    localparam logic [3:0]  c_WAIT_INIT      = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------------
    logic [31:0]     mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [c_AW-1:0] idx_q, idx_d;          // word index of the accepted fetch
    logic [1:0]      cause_q, cause_d;      // classification of the accepted fetch
    logic [31:0]     instr_q;               // data-phase instruction, held outside DATA
    logic [1:0]      data_cause_q;          // cause presented in the data phase

    // ------------------------------------------------------------------------
    // Address-phase classification (combinational on the live address)
    // ------------------------------------------------------------------------
    logic            w_ready;
    logic            w_accept;
    logic [31:0]     w_offset;
    logic            w_misaligned;
    logic            w_below;
    logic            w_beyond;
    logic [1:0]      w_cause_now;
    logic [c_AW-1:0] w_idx_now;
    logic            w_enter_data;

    assign w_ready  = (state_q != S_WAIT);
    assign w_accept = bus.fetch_req_in & w_ready;

    // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
    assign w_offset     = bus.imaddr_in - BASE_ADDR;
    assign w_misaligned = (w_offset[1:0] != 2'b00);
    assign w_below      = (bus.imaddr_in < BASE_ADDR);
    assign w_beyond     = ({2'b00, w_offset[31:2]} >= 32'(DEPTH));
    assign w_idx_now    = w_offset[c_AW+1:2];

    always_comb begin
        w_cause_now = c_CAUSE_NONE;
        if (w_misaligned) begin
            w_cause_now = c_CAUSE_MISALIGN;     // misalignment wins over range
        end else if (w_below || w_beyond) begin
            w_cause_now = c_CAUSE_RANGE;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cause_d = cause_q;

        case (state_q)
            S_IDLE, S_DATA: begin
                if (w_accept) begin
                    idx_d   = w_idx_now;
                    cause_d = w_cause_now;
                    if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Master holds its request here; the bus is not sampled.
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The array is read on the edge that enters DATA. idx_d/cause_d already
    // select between a fresh accept (zero wait states, pipelined) and the
    // fetch held through WAIT.
    assign w_enter_data = (state_d == S_DATA);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            cause_q      <= c_CAUSE_NONE;
            instr_q      <= c_NOP;
            data_cause_q <= c_CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            if (w_enter_data) begin
                // Non-blocking read of mem_q gives read-before-write against
                // a preload to the same word on this edge.
                instr_q      <= (cause_d == c_CAUSE_NONE) ? mem_q[idx_d] : c_NOP;
                data_cause_q <= cause_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Instruction array preload (not affected by reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (load_en_in) begin
            mem_q[load_addr_in] <= load_data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ahb_ready_out   = w_ready;
    assign bus.instr_valid_out = (state_q == S_DATA);
    assign bus.instr_out       = instr_q;
    assign bus.err_out         = (state_q == S_DATA) && (data_cause_q != c_CAUSE_NONE);
    assign bus.err_cause_out   = (state_q == S_DATA) ? data_cause_q : c_CAUSE_NONE;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_imem_responder
// Description : Drives one stimulus stream into two responders (one and zero
//               wait states) sharing a preload port, and compares every cycle
//               against a transaction-level model: accepted fetches are due a
//               fixed number of cycles later, the word is taken from a model
//               array at the read edge before that edge's preload write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_imem_responder;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic [31:0]   addr;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    msrv32_imem_responder_if bus0 ();
    msrv32_imem_responder_if bus1 ();

    assign bus0.fetch_req_in = req;
    assign bus0.imaddr_in    = addr;
    assign bus1.fetch_req_in = req;
    assign bus1.imaddr_in    = addr;

    msrv32_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut0 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus0),
        .load_en_in           (load_en),
        .load_addr_in         (load_addr),
        .load_data_in         (load_data)
    );

    msrv32_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut1 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus1),
        .load_en_in           (load_en),
        .load_addr_in         (load_addr),
        .load_data_in         (load_data)
    );

    logic [1:0]  o_rdy, o_vld, o_err;
    logic [31:0] o_instr [2];
    logic [1:0]  o_cause [2];

    assign o_rdy[0]   = bus0.ahb_ready_out;
    assign o_vld[0]   = bus0.instr_valid_out;
    assign o_err[0]   = bus0.err_out;
    assign o_instr[0] = bus0.instr_out;
    assign o_cause[0] = bus0.err_cause_out;
    assign o_rdy[1]   = bus1.ahb_ready_out;
    assign o_vld[1]   = bus1.instr_valid_out;
    assign o_err[1]   = bus1.err_out;
    assign o_instr[1] = bus1.instr_out;
    assign o_cause[1] = bus1.err_cause_out;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int          checks;
    int          errors;
    int          cyc;
    int          ws      [2];
    int          acc_c   [2];
    bit          p_valid [2];
    int          p_d     [2];
    logic [31:0] p_addr  [2];
    logic [1:0]  p_cause [2];
    logic [31:0] p_instr [2];
    logic [31:0] last_instr [2];
    logic [31:0] mmem [DEPTH];
    logic [31:0] plan [4];

    function automatic logic [1:0] classify(input logic [31:0] a);
        if ((a % 4) != 0)                  return 2'b01;
        if (a < BASE)                      return 2'b10;
        if (((a - BASE) / 4) >= 32'(DEPTH)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a - BASE) / 4);
    endfunction

    // Ready is low only for the ws[k] cycles immediately after an accept.
    function automatic bit exp_ready(input int k);
        return !((cyc > acc_c[k]) && (cyc <= acc_c[k] + ws[k]));
    endfunction

    function automatic void reset_model();
        for (int k = 0; k < 2; k++) begin
            p_valid[k]    = 1'b0;
            acc_c[k]      = -100;
            last_instr[k] = NOP;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          ev;
        logic [31:0] ei;
        logic [1:0]  ec;
        for (int k = 0; k < 2; k++) begin
            if (req && exp_ready(k)) begin
                p_valid[k] = 1'b1;
                p_d[k]     = cyc + ws[k] + 1;
                p_addr[k]  = addr;
                p_cause[k] = classify(addr);
                acc_c[k]   = cyc;
            end
            if (p_valid[k] && (p_d[k] == cyc + 1)) begin
                p_instr[k] = (p_cause[k] == 2'b00) ? mmem[word_of(p_addr[k])] : NOP;
            end
        end
        if (load_en) mmem[load_addr] = load_data;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (p_valid[k] && (p_d[k] == cyc)) begin
                ev            = 1'b1;
                ei            = p_instr[k];
                ec            = p_cause[k];
                last_instr[k] = p_instr[k];
                p_valid[k]    = 1'b0;
            end else begin
                ev = 1'b0;
                ei = last_instr[k];
                ec = 2'b00;
            end
            chk($sformatf("dut%0d_ready c%0d", k, cyc), 32'(o_rdy[k]), 32'(exp_ready(k)));
            chk($sformatf("dut%0d_valid c%0d", k, cyc), 32'(o_vld[k]), 32'(ev));
            chk($sformatf("dut%0d_instr c%0d", k, cyc), o_instr[k], ei);
            chk($sformatf("dut%0d_err c%0d", k, cyc), 32'(o_err[k]), 32'(ec != 2'b00));
            chk($sformatf("dut%0d_cause c%0d", k, cyc), 32'(o_cause[k]), 32'(ec));
        end
    endtask

    task automatic do_reset();
        req     = 1'b0;
        load_en = 1'b0;
        rst_n   = 1'b0;
        reset_model();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_ready", k), 32'(o_rdy[k]), 32'd1);
            chk($sformatf("rst%0d_valid", k), 32'(o_vld[k]), 32'd0);
            chk($sformatf("rst%0d_instr", k), o_instr[k], NOP);
            chk($sformatf("rst%0d_err", k), 32'(o_err[k]), 32'd0);
            chk($sformatf("rst%0d_cause", k), 32'(o_cause[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence followed by random traffic
    // ------------------------------------------------------------------------
    initial begin
        int r;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        ws[0]     = 1;
        ws[1]     = 0;
        rst_n     = 1'b1;
        req       = 1'b0;
        addr      = 32'h0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'h0;
        plan[0]   = 32'h0050_0093;
        plan[1]   = 32'h0010_0113;
        plan[2]   = 32'h0020_81B3;
        plan[3]   = 32'h0000_006F;
        reset_model();
        #1;
        do_reset();
        tick();
        tick();

        // Preload the whole array, then the program words.
        load_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_addr = AW'(i);
            load_data = $urandom;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            load_addr = AW'(i);
            load_data = plan[i];
            tick();
        end
        load_en = 1'b0;
        tick();

        // One wait state: fetch 0x0, then 0x4 with a stray request during WAIT.
        req = 1'b1; addr = 32'h0;
        tick();
        chk("ws1_ready_low", 32'(o_rdy[0]), 32'd0);
        req = 1'b0;
        tick();
        chk("ws1_valid0", 32'(o_vld[0]), 32'd1);
        chk("ws1_instr0", o_instr[0], 32'h0050_0093);
        req = 1'b1; addr = 32'h4;
        tick();
        addr = 32'hC;                         // ignored while waiting
        tick();
        chk("ws1_valid4", 32'(o_vld[0]), 32'd1);
        chk("ws1_instr4_held_addr", o_instr[0], 32'h0010_0113);
        req = 1'b0;
        tick();
        tick();

        // Zero wait states: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            req  = 1'b1;
            addr = 32'(i * 4);
            tick();
            chk($sformatf("ws0_ready%0d", i), 32'(o_rdy[1]), 32'd1);
            chk($sformatf("ws0_valid%0d", i), 32'(o_vld[1]), 32'd1);
            chk($sformatf("ws0_instr%0d", i), o_instr[1], plan[i]);
        end
        req = 1'b0;
        tick();
        tick();
        tick();

        // Error classes and priority.
        req = 1'b1; addr = 32'h0000_0006;
        tick();
        chk("ws0_misalign_cause", 32'(o_cause[1]), 32'd1);
        req = 1'b0;
        tick();
        chk("misalign_err", 32'(o_err[0]), 32'd1);
        chk("misalign_cause", 32'(o_cause[0]), 32'd1);
        chk("misalign_nop", o_instr[0], NOP);
        tick();
        req = 1'b1; addr = 32'h0000_1000;
        tick();
        req = 1'b0;
        tick();
        chk("range_cause", 32'(o_cause[0]), 32'd2);
        tick();
        req = 1'b1; addr = 32'h0000_1002;
        tick();
        req = 1'b0;
        tick();
        chk("priority_cause", 32'(o_cause[0]), 32'd1);
        tick();

        // Preload on the read edge: old word returned, new word on refetch.
        req = 1'b1; addr = 32'h8;
        tick();
        req = 1'b0; load_en = 1'b1; load_addr = AW'(2); load_data = 32'hDEAD_BEEF;
        tick();
        chk("rbw_old_word", o_instr[0], 32'h0020_81B3);
        load_en = 1'b0;
        tick();
        req = 1'b1; addr = 32'h8;
        tick();
        req = 1'b0;
        tick();
        chk("rbw_new_word", o_instr[0], 32'hDEAD_BEEF);
        tick();

        // Reset while waiting: the fetch is dropped.
        req = 1'b1; addr = 32'h0;
        tick();
        do_reset();
        tick();
        chk("rst_wait_no_valid", 32'(o_vld[0]), 32'd0);
        chk("rst_wait_ready", 32'(o_rdy[0]), 32'd1);
        tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            req = ($urandom_range(9, 0) < 7);
            r   = $urandom_range(9, 0);
            if (r < 6)       addr = 32'($urandom_range(DEPTH - 1, 0)) << 2;
            else if (r < 8)  addr = (32'($urandom_range(DEPTH - 1, 0)) << 2) | 32'($urandom_range(3, 1));
            else if (r < 9)  addr = 32'($urandom_range(32'h3FFF_FFFF, DEPTH)) << 2;
            else             addr = $urandom;
            load_en   = ($urandom_range(4, 0) == 0);
            load_addr = AW'($urandom_range(DEPTH - 1, 0));
            load_data = $urandom;
            tick();
        end
        req     = 1'b0;
        load_en = 1'b0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
